wb_stage: RTL and testbench

- Writeback stage of the 5-stage integer pipeline. Drives the register file write port (wb_we, wb_waddr, wb_wdata).
- Captures each retiring instruction from the MEM stage.
- For loads: waits for the data-memory read response, aligns and sign- or zero-extends the data, then issues exactly one register write.
- Stalls upstream while a load is outstanding and supports pipeline flush.

---
 rtl/wb_stage.sv | 186 ++++++++++++++++++
 tb/tb_wb_stage.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage
// Brief    : Pipeline writeback stage. Issues register writes for ALU results
//            and load responses (aligned and extended), and stalls upstream
//            while a load is in flight.
// Revision : 1.0  initial release
// ============================================================================
module wb_stage #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          mem_valid,
    input  logic          mem_wreg,
    input  logic [AW-1:0] mem_waddr,
    input  logic [DW-1:0] mem_wdata,
    input  logic          mem_is_load,
    input  logic [2:0]    mem_load_type,
    input  logic [1:0]    mem_byte_off,
    input  logic          flush,
    input  logic          dmem_rvalid,
    input  logic [DW-1:0] dmem_rdata,
    output logic          wb_stall,
    output logic          wb_we,
    output logic [AW-1:0] wb_waddr,
    output logic [DW-1:0] wb_wdata,
    output logic          wb_retire,
    output logic          wb_misalign
);

    localparam logic [2:0] C_LB  = 3'b000;
    localparam logic [2:0] C_LH  = 3'b001;
    localparam logic [2:0] C_LW  = 3'b010;
    localparam logic [2:0] C_LBU = 3'b100;
    localparam logic [2:0] C_LHU = 3'b101;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic          ld_wreg_q, ld_wreg_d;
    logic [AW-1:0] ld_waddr_q, ld_waddr_d;
    logic [2:0]    ld_type_q, ld_type_d;
    logic [1:0]    ld_off_q, ld_off_d;

    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          retire_q, retire_d;
    logic          misalign_q, misalign_d;

    logic [DW-1:0] w_shifted;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [DW-1:0] w_aligned;
    logic          w_load_ok;

    // Byte lane select by shifting; halfword lanes are picked by the upper offset bit.
    assign w_shifted = dmem_rdata >> {ld_off_q, 3'b000};
    assign w_byte    = w_shifted[7:0];
    assign w_half    = ld_off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        w_aligned = dmem_rdata;
        w_load_ok = 1'b0;
        case (ld_type_q)
            C_LB: begin
                w_aligned = {{24{w_byte[7]}}, w_byte};
                w_load_ok = 1'b1;
            end
            C_LBU: begin
                w_aligned = {24'd0, w_byte};
                w_load_ok = 1'b1;
            end
            C_LH: begin
                w_aligned = {{16{w_half[15]}}, w_half};
                w_load_ok = ~ld_off_q[0];
            end
            C_LHU: begin
                w_aligned = {16'd0, w_half};
                w_load_ok = ~ld_off_q[0];
            end
            C_LW: begin
                w_aligned = dmem_rdata;
                w_load_ok = (ld_off_q == 2'b00);
            end
            default: begin
                w_aligned = dmem_rdata;
                w_load_ok = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ld_wreg_d  = ld_wreg_q;
        ld_waddr_d = ld_waddr_q;
        ld_type_d  = ld_type_q;
        ld_off_d   = ld_off_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        retire_d   = 1'b0;
        misalign_d = 1'b0;

        if (flush) begin
            state_d    = S_IDLE;
            ld_wreg_d  = 1'b0;
            ld_waddr_d = '0;
            ld_type_d  = '0;
            ld_off_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mem_valid) begin
                        if (mem_is_load) begin
                            ld_wreg_d  = mem_wreg;
                            ld_waddr_d = mem_waddr;
                            ld_type_d  = mem_load_type;
                            ld_off_d   = mem_byte_off;
                            state_d    = S_WAIT;
                        end else begin
                            we_d     = mem_wreg && (mem_waddr != '0);
                            waddr_d  = mem_waddr;
                            wdata_d  = mem_wdata;
                            retire_d = 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (dmem_rvalid) begin
                        state_d  = S_IDLE;
                        retire_d = 1'b1;
                        if (w_load_ok) begin
                            we_d    = ld_wreg_q && (ld_waddr_q != '0);
                            waddr_d = ld_waddr_q;
                            wdata_d = w_aligned;
                        end else begin
                            misalign_d = 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            ld_wreg_q  <= 1'b0;
            ld_waddr_q <= '0;
            ld_type_q  <= '0;
            ld_off_q   <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            retire_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ld_wreg_q  <= ld_wreg_d;
            ld_waddr_q <= ld_waddr_d;
            ld_type_q  <= ld_type_d;
            ld_off_q   <= ld_off_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            retire_q   <= retire_d;
            misalign_q <= misalign_d;
        end
    end

    assign wb_stall    = (state_q == S_WAIT);
    assign wb_we       = we_q;
    assign wb_waddr    = waddr_q;
    assign wb_wdata    = wdata_q;
    assign wb_retire   = retire_q;
    assign wb_misalign = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_stage
// Brief    : Scoreboard bench for wb_stage with directed and random traffic.
// Revision : 1.0  initial release
// ============================================================================
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_valid, mem_wreg, mem_is_load, flush, dmem_rvalid;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata, dmem_rdata;
    logic [2:0]  mem_load_type;
    logic [1:0]  mem_byte_off;
    logic        wb_stall, wb_we, wb_retire, wb_misalign;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;

    always #5 clk = ~clk;

    wb_stage #(.DW(32), .AW(5)) dut (
        .clk(clk), .reset_n(reset_n),
        .mem_valid(mem_valid), .mem_wreg(mem_wreg), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .mem_is_load(mem_is_load),
        .mem_load_type(mem_load_type), .mem_byte_off(mem_byte_off),
        .flush(flush), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_stall(wb_stall), .wb_we(wb_we), .wb_waddr(wb_waddr),
        .wb_wdata(wb_wdata), .wb_retire(wb_retire), .wb_misalign(wb_misalign)
    );

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        mis;
    } exp_t;

    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;
    bit          mon_en = 0;
    logic [4:0]  last_waddr = '0;
    logic [31:0] last_wdata = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Load result from the architectural rules: extract lane with arithmetic, then extend.
    function automatic logic [31:0] ref_load(input int t, input int off, input logic [31:0] d,
                                             output bit ok);
        longint w;
        longint b;
        longint h;
        longint v;
        w  = longint'({32'd0, d});
        b  = (w >> (8 * off)) % 256;
        h  = (w >> (8 * off)) % 65536;
        ok = 1'b0;
        v  = w;
        case (t)
            0: begin ok = 1'b1; v = (b >= 128) ? b - 256 : b; end
            4: begin ok = 1'b1; v = b; end
            1: begin ok = (off % 2 == 0); v = (h >= 32768) ? h - 65536 : h; end
            5: begin ok = (off % 2 == 0); v = h; end
            2: begin ok = (off == 0); v = w; end
            default: ok = 1'b0;
        endcase
        return v[31:0];
    endfunction

    task automatic idle_inputs();
        mem_valid = 1'b0; mem_is_load = 1'b0; flush = 1'b0; dmem_rvalid = 1'b0;
    endtask

    task automatic alu(input logic wreg, input logic [4:0] wa, input logic [31:0] wd);
        mem_valid = 1'b1; mem_is_load = 1'b0; mem_wreg = wreg;
        mem_waddr = wa; mem_wdata = wd;
        mem_load_type = 3'($urandom); mem_byte_off = 2'($urandom);
        dmem_rvalid = 1'($urandom); dmem_rdata = $urandom;
        q.push_back('{we: wreg && (wa != 0), waddr: wa, wdata: wd, mis: 1'b0});
        last_waddr = wa; last_wdata = wd;
        tick();
        idle_inputs();
    endtask

    task automatic do_load(input int t, input int off, input logic [4:0] wa, input logic wreg,
                           input int nwait, input logic [31:0] rd, input bit held);
        bit          ok;
        logic [31:0] v;
        logic        h_wreg;
        logic [4:0]  h_wa;
        logic [31:0] h_wd;
        h_wreg = 1'($urandom); h_wa = 5'($urandom); h_wd = $urandom;
        mem_valid = 1'b1; mem_is_load = 1'b1; mem_load_type = t[2:0];
        mem_byte_off = off[1:0]; mem_waddr = wa; mem_wreg = wreg; mem_wdata = $urandom;
        dmem_rvalid = 1'($urandom); dmem_rdata = $urandom;
        tick();
        for (int i = 0; i < nwait; i++) begin
            check("stall_in_wait", 32'(wb_stall), 32'd1);
            if (i == nwait - 1) begin
                dmem_rvalid = 1'b1; dmem_rdata = rd;
                v = ref_load(t, off, rd, ok);
                if (ok) begin
                    q.push_back('{we: wreg && (wa != 0), waddr: wa, wdata: v, mis: 1'b0});
                    last_waddr = wa; last_wdata = v;
                end else begin
                    q.push_back('{we: 1'b0, waddr: last_waddr, wdata: last_wdata, mis: 1'b1});
                end
                mem_valid = held; mem_is_load = 1'b0;
                mem_wreg = h_wreg; mem_waddr = h_wa; mem_wdata = h_wd;
            end else begin
                dmem_rvalid = 1'b0;
                mem_valid = 1'($urandom); mem_is_load = 1'($urandom);
                mem_wreg = 1'($urandom); mem_waddr = 5'($urandom); mem_wdata = $urandom;
                mem_load_type = 3'($urandom); mem_byte_off = 2'($urandom);
            end
            tick();
        end
        check("stall_after_rvalid", 32'(wb_stall), 32'd0);
        dmem_rvalid = 1'b0;
        if (held) begin
            q.push_back('{we: h_wreg && (h_wa != 0), waddr: h_wa, wdata: h_wd, mis: 1'b0});
            last_waddr = h_wa; last_wdata = h_wd;
            tick();
        end
        idle_inputs();
    endtask

    task automatic flushed_load(input int flush_cycle, input int rv_delay);
        mem_valid = 1'b1; mem_is_load = 1'b1; mem_load_type = 3'($urandom);
        mem_byte_off = 2'($urandom); mem_waddr = 5'($urandom); mem_wreg = 1'b1;
        tick();
        mem_valid = 1'b0;
        for (int i = 1; i < flush_cycle; i++) begin
            check("stall_before_flush", 32'(wb_stall), 32'd1);
            tick();
        end
        flush = 1'b1; dmem_rvalid = 1'($urandom); dmem_rdata = $urandom;
        mem_valid = 1'($urandom); mem_is_load = 1'($urandom);
        tick();
        idle_inputs();
        check("stall_after_flush", 32'(wb_stall), 32'd0);
        for (int i = 1; i < rv_delay; i++) tick();
        dmem_rvalid = 1'b1; dmem_rdata = $urandom;
        tick();
        idle_inputs();
    endtask

    // Monitor: every retire pops one expectation; no write/misalign without a retire.
    initial begin
        exp_t e;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (wb_retire === 1'b1) begin
                    if (q.size() == 0) begin
                        check("unexpected_retire", 32'(wb_retire), 32'd0);
                    end else begin
                        e = q.pop_front();
                        check("wb_we", 32'(wb_we), 32'(e.we));
                        check("wb_misalign", 32'(wb_misalign), 32'(e.mis));
                        check("wb_waddr", 32'(wb_waddr), 32'(e.waddr));
                        check("wb_wdata", wb_wdata, e.wdata);
                    end
                end else begin
                    check("idle_we", 32'(wb_we), 32'd0);
                    check("idle_misalign", 32'(wb_misalign), 32'd0);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; idle_inputs();
        mem_wreg = 1'b0; mem_waddr = '0; mem_wdata = '0;
        mem_load_type = '0; mem_byte_off = '0; dmem_rdata = '0;
        repeat (3) tick();
        check("rst_we", 32'(wb_we), 32'd0);
        check("rst_waddr", 32'(wb_waddr), 32'd0);
        check("rst_wdata", wb_wdata, 32'd0);
        check("rst_retire", 32'(wb_retire), 32'd0);
        check("rst_misalign", 32'(wb_misalign), 32'd0);
        check("rst_stall", 32'(wb_stall), 32'd0);
        reset_n = 1'b1;
        mon_en = 1'b1;
        tick();

        // Directed cases
        alu(1'b1, 5'd5, 32'h1234_5678);
        tick();
        do_load(0, 3, 5'd7, 1'b1, 1, 32'h80FF_0011, 1'b0);
        do_load(5, 2, 5'd9, 1'b1, 4, 32'hBEEF_0001, 1'b1);
        do_load(2, 1, 5'd3, 1'b1, 1, 32'h1111_2222, 1'b0);
        do_load(2, 0, 5'd3, 1'b1, 1, 32'hCAFE_F00D, 1'b0);
        flushed_load(2, 2);
        alu(1'b1, 5'd0, 32'hDEAD_BEEF);
        do_load(3, 0, 5'd4, 1'b1, 2, 32'h0000_0001, 1'b0);
        do_load(1, 2, 5'd0, 1'b1, 1, 32'h8001_0000, 1'b0);

        // Dangling response in IDLE must be ignored
        dmem_rvalid = 1'b1; dmem_rdata = $urandom;
        tick();
        idle_inputs();

        // Reset in the middle of WAIT drops the load
        mem_valid = 1'b1; mem_is_load = 1'b1; mem_load_type = 3'd2;
        mem_byte_off = 2'd0; mem_waddr = 5'd6; mem_wreg = 1'b1;
        tick();
        idle_inputs();
        check("stall_pre_reset", 32'(wb_stall), 32'd1);
        reset_n = 1'b0;
        tick();
        check("midrst_stall", 32'(wb_stall), 32'd0);
        check("midrst_we", 32'(wb_we), 32'd0);
        check("midrst_waddr", 32'(wb_waddr), 32'd0);
        check("midrst_wdata", wb_wdata, 32'd0);
        check("midrst_retire", 32'(wb_retire), 32'd0);
        reset_n = 1'b1;
        last_waddr = '0; last_wdata = '0;
        dmem_rvalid = 1'b1; dmem_rdata = $urandom;
        tick();
        idle_inputs();

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: alu(1'($urandom), 5'($urandom), $urandom);
                4, 5, 6:    do_load($urandom_range(0, 7), $urandom_range(0, 3), 5'($urandom),
                                    1'($urandom), $urandom_range(1, 4), $urandom, 1'($urandom));
                7:          flushed_load($urandom_range(1, 3), $urandom_range(1, 3));
                default: begin
                    dmem_rvalid = 1'($urandom); dmem_rdata = $urandom;
                    tick();
                    idle_inputs();
                end
            endcase
        end

        for (int i = 0; i < 10 && q.size() != 0; i++) tick();
        repeat (2) tick();
        check("queue_drained", 32'(q.size()), 32'd0);
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
